// File: rtl/vol_pkg.sv
// Shared types and defaults for the volume level controller.
// Repeat FSM states, step direction and DAC amplitude constants.
package vol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RPT
  } rpt_state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_t;

  localparam int unsigned VOL_MID  = 32'h8000;
  localparam int unsigned VOL_STEP = 2000;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_hold_repeat.sv
// Button edge detect with hold-to-auto-repeat.
// Emits a one-cycle step pulse and its direction.
module btn_hold_repeat
  import vol_pkg::*;
#(
  parameter int unsigned HOLD_DLY = 50000000,
  parameter int unsigned RPT_PER  = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic up,
  input  logic dn,
  output logic step,
  output dir_t dir
);

  localparam int unsigned CW =
    $clog2(max_u(HOLD_DLY, RPT_PER));
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_DLY - 1);
  localparam logic [CW-1:0] RPT_LAST =
    CW'(RPT_PER - 1);

  rpt_state_t    state;
  dir_t          dir_q;
  dir_t          dir_c;
  dir_t          req_dir;
  logic [CW-1:0] cnt;
  logic          up_q;
  logic          dn_q;
  logic          up_req;
  logic          dn_req;
  logic          req_any;
  logic          same;
  logic          up_rise;
  logic          dn_rise;
  logic          step_c;

  assign up_req  = up & ~dn;
  assign dn_req  = dn & ~up;
  assign req_any = up_req | dn_req;
  assign req_dir = up_req ? DIR_UP : DIR_DN;
  assign same    = req_any && (req_dir == dir_q);
  assign up_rise = up_req & ~up_q;
  assign dn_rise = dn_req & ~dn_q;

  always_comb begin
    step_c = 1'b0;
    dir_c  = dir_q;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          up_rise: begin
            step_c = 1'b1;
            dir_c  = DIR_UP;
          end
          dn_rise: begin
            step_c = 1'b1;
            dir_c  = DIR_DN;
          end
          default: ;
        endcase
      end
      DELAY: step_c = same && (cnt == HOLD_LAST);
      RPT:   step_c = same && (cnt == RPT_LAST);
      default: ;
    endcase
  end

  assign step = step_c;
  assign dir  = dir_c;

  // Edge registers reset high: a button held through reset
  // must be released and pressed again before it steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dir_q <= DIR_UP;
      cnt   <= '0;
      up_q  <= 1'b1;
      dn_q  <= 1'b1;
    end else begin
      up_q <= up_req;
      dn_q <= dn_req;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (step_c) begin
            state <= DELAY;
            dir_q <= dir_c;
          end
        end
        DELAY, RPT: begin
          if (!same) begin
            state <= IDLE;
            cnt   <= '0;
            // Direction swap: let IDLE see the new edge
            if (up_req) up_q <= 1'b0;
            if (dn_req) dn_q <= 1'b0;
          end else if (step_c) begin
            state <= RPT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/volume_level_ctrl.sv
// Saturating volume level with mute and flags.
// Drives a registered DAC amplitude MID + level*STEP.
module volume_level_ctrl
  import vol_pkg::*;
#(
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned MAX_LEVEL = 15,
  parameter int unsigned AMP_W     = 16,
  parameter int unsigned MID       = VOL_MID,
  parameter int unsigned STEP      = VOL_STEP,
  parameter int unsigned HOLD_DLY  = 50000000,
  parameter int unsigned RPT_PER   = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vol_up,
  input  logic               vol_down,
  input  logic               mute_tgl,
  output logic [LEVEL_W-1:0] level,
  output logic               muted,
  output logic               at_max,
  output logic               at_min,
  output logic [AMP_W-1:0]   volume
);

  localparam longint unsigned AMP_TOP =
    64'(MID) + 64'(MAX_LEVEL) * 64'(STEP);
  localparam logic [LEVEL_W-1:0] LVL_MAX =
    LEVEL_W'(MAX_LEVEL);
  localparam logic [AMP_W-1:0] AMP_MID =
    AMP_W'(MID);
  localparam logic [AMP_W-1:0] AMP_STEP =
    AMP_W'(STEP);

  if (AMP_TOP >= (64'd1 << AMP_W)) begin : g_amp_chk
    $error("volume_level_ctrl: MID+MAX_LEVEL*STEP overflows AMP_W");
  end

  if (MAX_LEVEL < 1 ||
      MAX_LEVEL > (2 ** LEVEL_W) - 1) begin : g_lvl_chk
    $error("volume_level_ctrl: MAX_LEVEL out of range");
  end

  dir_t               dir;
  logic               step;
  logic               mute_q;
  logic               mute_rise;
  logic               muted_nx;
  logic [LEVEL_W-1:0] level_nx;
  logic [AMP_W-1:0]   amp_nx;

  btn_hold_repeat #(
    .HOLD_DLY (HOLD_DLY),
    .RPT_PER  (RPT_PER)
  ) u_rpt (
    .clk  (clk),
    .rst  (rst),
    .up   (vol_up),
    .dn   (vol_down),
    .step (step),
    .dir  (dir)
  );

  assign mute_rise = mute_tgl & ~mute_q;
  assign muted_nx  = muted ^ mute_rise;

  always_comb begin
    level_nx = level;
    unique case (1'b1)
      step && dir == DIR_UP && level != LVL_MAX:
        level_nx = level + 1'b1;
      step && dir == DIR_DN && level != '0:
        level_nx = level - 1'b1;
      default: ;
    endcase
  end

  // Amplitude trails level/muted by one register stage
  assign amp_nx = muted ? AMP_MID :
    AMP_MID + AMP_W'(level) * AMP_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level  <= '0;
      muted  <= 1'b0;
      at_max <= 1'b0;
      at_min <= 1'b1;
      volume <= AMP_MID;
      mute_q <= 1'b1;
    end else begin
      mute_q <= mute_tgl;
      level  <= level_nx;
      muted  <= muted_nx;
      at_max <= (level_nx == LVL_MAX);
      at_min <= (level_nx == '0);
      volume <= amp_nx;
    end
  end

endmodule
